mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory bus between the IF stage (instruction fetch) and MEM stage (lw/sw).
//  Sits between the 5-stage pipeline and the memory; returns if_stall / mem_stall to the pipeline controller,
//  which holds the stage (en=0) while its stall is high. MEM has priority; a starvation counter guarantees IF progress.
//  A bus watchdog terminates hung transfers and flags an error.
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width
//  MAX_STARVE  4    consecutive MEM grants with IF pending before IF is forced to win
//  TIMEOUT     255  BUSY cycles without bus_ack before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk         in   1       main clock
//  rst         in   1       asynchronous, active-high reset
//  if_req      in   1       IF read request; held with if_addr until if_ack
//  if_addr     in   ADDR_W  fetch address
//  if_rdata    out  DATA_W  fetched word, valid while if_ack=1
//  if_ack      out  1       one-cycle completion pulse to IF
//  if_stall    out  1       if_req & ~if_ack
//  mem_req     in   1       MEM request; held with mem_wen/addr/wdata until mem_ack
//  mem_wen     in   1       1=store, 0=load
//  mem_addr    in   ADDR_W  data address
//  mem_wdata   in   DATA_W  store data
//  mem_rdata   out  DATA_W  load data, valid while mem_ack=1
//  mem_ack     out  1       one-cycle completion pulse to MEM
//  mem_stall   out  1       mem_req & ~mem_ack
//  bus_cyc     out  1       bus transfer active; held until bus_ack or timeout
//  bus_we      out  1       write strobe
//  bus_addr    out  ADDR_W  registered address
//  bus_wdata   out  DATA_W  registered write data
//  bus_rdata   in   DATA_W  read data, valid with bus_ack
//  bus_ack     in   1       transfer complete (any cycle while bus_cyc=1)
//  bus_err     out  1       sticky: a transfer timed out; cleared only by rst
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; starve_cnt=0; wdog=0; response regs 0. Reset mid-transfer drops bus_cyc immediately; no ack issued.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if any req, pick winner, register bus_we/addr/wdata and owner, -> BUSY. No req: stay.
//    BUSY: bus_cyc=1. bus_ack: capture bus_rdata into resp reg, -> RESP. wdog==TIMEOUT-1 without ack: resp=0, set bus_err, -> RESP.
//    RESP: bus_cyc=0; owner's ack=1 for exactly this cycle with its rdata=resp; -> IDLE (no arbitration in RESP).
//  - Minimum latency: req at cycle N -> bus_cyc at N+1 -> bus_ack at N+1 -> ack at N+2. Throughput 1 transfer / 3 cycles min.
//  - Arbitration (IDLE only): both req -> MEM wins unless starve_cnt==MAX_STARVE, then IF wins.
//    starve_cnt: +1 on each MEM grant while if_req=1 (saturating at MAX_STARVE); cleared on any IF grant.
//  - wdog counts BUSY cycles; cleared on entering BUSY. Timed-out store: ack still returned, write assumed lost.
//  - bus_we=0 for IF grants always. Bus outputs stable throughout BUSY; cleared to 0 in IDLE/RESP.
//  - Requester dropping req during BUSY: transfer completes, ack still pulsed (protocol violation, not detected).
//  - rdata outputs are 0 except in the owner's RESP cycle.
//  - Stalls are combinational from req and registered ack; no combinational path from bus_* to any output.
// STRUCTURE
//  - Shared header mem_arb_define.vh: state encodings ARB_IDLE/ARB_BUSY/ARB_RESP, owner codes OWN_IF/OWN_MEM.
//  - One sub-module: mem_arb_wdog (watchdog counter: clear, enable, expire compare against TIMEOUT).
//  - Arbitration and starvation logic stay inline.
// TESTING
//  1. IF only, bus_ack 1 cycle after bus_cyc, bus_rdata=32'h2402_0005 -> if_ack pulse at req+2, if_rdata=32'h24020005, if_stall high cycles 0-1.
//  2. if_req and mem_req (sw, addr 0x10, wdata 0xDEAD_BEEF) same cycle -> MEM granted first: bus_we=1, bus_addr=0x10; IF granted next IDLE.
//  3. IF held, MEM re-requests each IDLE (MAX_STARVE=4) -> 4 MEM grants, 5th grant to IF, starve_cnt back to 0.
//  4. bus_ack never asserted (TIMEOUT=8) -> bus_cyc high 8 cycles, then owner ack with rdata=0, bus_err=1 and sticky after.
//  5. rst asserted in BUSY -> bus_cyc=0 same cycle (async), no ack; after release, pending req re-arbitrated from IDLE.
//  6. bus_ack 5 cycles late on lw -> mem_stall high 7 cycles, mem_ack single pulse, bus_addr/we stable through BUSY.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the IF/MEM memory port arbiter
//
// Purpose: FSM state encodings and bus-owner codes used by mem_port_arbiter.
// Ports:   none (package).

package mem_port_arbiter_pkg;

   // Transfer sequencing: arbitrate in IDLE, hold the bus in BUSY,
   // return the response to the owner in RESP.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Which pipeline stage owns the transfer in flight.
   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_wdog.sv
// rtl/mem_port_arbiter_wdog.sv - bus watchdog counter for the memory port arbiter
//
// Purpose: counts cycles while enabled and flags expiry on the TIMEOUT-th
//          enabled cycle, so a hung transfer can be terminated.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   clr_i     in  synchronous clear (takes priority over en_i)
//   en_i      in  count enable
//   expire_o  out high while enabled and the count has reached TIMEOUT-1

module mem_arb_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count starts at 0 in the first enabled cycle, so TIMEOUT-1 marks
   // the TIMEOUT-th cycle.
   assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between the IF and MEM pipeline stages
//
// Purpose: arbitrates IF fetches and MEM loads/stores onto a single-ported bus.
//          MEM has priority; a starvation counter forces an IF grant after
//          MAX_STARVE consecutive MEM grants with IF waiting. A watchdog ends
//          transfers that never see bus_ack and sets a sticky error.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req_i, if_addr_i            IF read request, held until if_ack_o
//   if_rdata_o, if_ack_o           IF response (rdata valid only with ack)
//   if_stall_o                     if_req_i & ~if_ack_o
//   mem_req_i, mem_wen_i,
//   mem_addr_i, mem_wdata_i        MEM request, held until mem_ack_o
//   mem_rdata_o, mem_ack_o         MEM response (rdata valid only with ack)
//   mem_stall_o                    mem_req_i & ~mem_ack_o
//   bus_cyc_o, bus_we_o,
//   bus_addr_o, bus_wdata_o        registered bus request, stable through BUSY
//   bus_rdata_i, bus_ack_i         bus response
//   bus_err_o                      sticky transfer-timeout flag

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STARVE = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   output logic              if_stall_o,
   input  logic              mem_req_i,
   input  logic              mem_wen_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_ack_o,
   output logic              mem_stall_o,
   output logic              bus_cyc_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ack_i,
   output logic              bus_err_o
);

   localparam int SW = $clog2(MAX_STARVE + 1);

   arb_state_e        state_q, state_d;
   arb_owner_e        owner_q, owner_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0] resp_q, resp_d;
   logic              err_q, err_d;

   logic starve_full;
   logic grant_mem;
   logic grant_if;
   logic wdog_expire;
   logic xfer_done;

   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (state_q != ARB_BUSY),
      .en_i     (state_q == ARB_BUSY),
      .expire_o (wdog_expire)
   );

   // MEM wins unless IF has been passed over MAX_STARVE times in a row.
   assign starve_full = (starve_q == SW'(MAX_STARVE));
   assign grant_mem   = mem_req_i && !(if_req_i && starve_full);
   assign grant_if    = if_req_i && !grant_mem;

   // A real ack wins over a simultaneous watchdog expiry.
   assign xfer_done   = bus_ack_i || wdog_expire;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: if (if_req_i || mem_req_i) state_d = ARB_BUSY;
         ARB_BUSY: if (xfer_done)             state_d = ARB_RESP;
         ARB_RESP:                            state_d = ARB_IDLE;
         default:                             state_d = ARB_IDLE;
      endcase
   end

   // Datapath next-state: grant capture, response capture, starvation count
   always_comb begin
      owner_d     = owner_q;
      starve_d    = starve_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      resp_d      = resp_q;
      err_d       = err_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant_mem) begin
               owner_d     = OWN_MEM;
               bus_we_d    = mem_wen_i;
               bus_addr_d  = mem_addr_i;
               bus_wdata_d = mem_wdata_i;
               // grant_mem with IF waiting implies the count is below
               // MAX_STARVE, so this increment saturates by construction.
               if (if_req_i) starve_d = starve_q + 1'b1;
            end else if (grant_if) begin
               owner_d     = OWN_IF;
               bus_we_d    = 1'b0;
               bus_addr_d  = if_addr_i;
               bus_wdata_d = '0;
               starve_d    = '0;
            end
         end
         ARB_BUSY: begin
            if (bus_ack_i) begin
               resp_d = bus_rdata_i;
            end else if (wdog_expire) begin
               resp_d = '0;
               err_d  = 1'b1;
            end
            // Bus request fields return to 0 as the transfer leaves BUSY.
            if (xfer_done) begin
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_wdata_d = '0;
            end
         end
         ARB_RESP: begin
            resp_d = '0;
         end
         default: begin
            resp_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q     <= OWN_IF;
         starve_q    <= '0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         resp_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         resp_q      <= resp_d;
         err_q       <= err_d;
      end
   end

   // Outputs: all decoded from registered state, never from bus_* inputs.
   always_comb begin
      bus_cyc_o   = (state_q == ARB_BUSY);
      if_ack_o    = (state_q == ARB_RESP) && (owner_q == OWN_IF);
      mem_ack_o   = (state_q == ARB_RESP) && (owner_q == OWN_MEM);
      if_rdata_o  = if_ack_o ? resp_q : '0;
      mem_rdata_o = mem_ack_o ? resp_q : '0;
      if_stall_o  = if_req_i && !if_ack_o;
      mem_stall_o = mem_req_i && !mem_ack_o;
   end

   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MS = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          if_stall;
   logic          mem_req = 1'b0;
   logic          mem_wen = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          mem_stall;
   logic          bus_cyc;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata = '0;
   logic          bus_ack = 1'b0;
   logic          bus_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
      .if_ack_o(if_ack), .if_stall_o(if_stall),
      .mem_req_i(mem_req), .mem_wen_i(mem_wen), .mem_addr_i(mem_addr),
      .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
      .mem_stall_o(mem_stall),
      .bus_cyc_o(bus_cyc), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
      .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
      .bus_err_o(bus_err)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus memory model: reads return a fixed function of the address.
   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return a ^ 32'h2402_0005;
   endfunction

   // Scoreboard of expected acks, in expected completion order.
   typedef struct {
      logic        is_mem;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb_q[$];

   task automatic push_exp(input logic is_mem, input logic [31:0] rdata);
      exp_t e;
      e.is_mem = is_mem;
      e.rdata  = rdata;
      sb_q.push_back(e);
   endtask

   // Bus responder: acks after ack_lat BUSY cycles, or never when no_ack.
   int          ack_lat = 0;
   bit          no_ack = 1'b0;
   int          busy_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   always @(negedge clk) begin
      if (bus_cyc) begin
         if (!no_ack && busy_cnt == ack_lat) begin
            bus_ack   = 1'b1;
            bus_rdata = bus_we ? 32'h0 : rd_model(bus_addr);
            if (bus_we) begin
               wr_cnt++;
               wr_addr = bus_addr;
               wr_data = bus_wdata;
            end
         end else begin
            bus_ack   = 1'b0;
            bus_rdata = '0;
         end
         busy_cnt++;
      end else begin
         busy_cnt  = 0;
         bus_ack   = 1'b0;
         bus_rdata = '0;
      end
   end

   // Monitor: pops the scoreboard on every ack and checks invariants.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (if_ack && mem_ack) begin
         tests++; fails++;
         $display("FAIL dual_ack: both acks high at %0t", $time);
      end
      if ((!if_ack && if_rdata !== '0) || (!mem_ack && mem_rdata !== '0)) begin
         tests++; fails++;
         $display("FAIL rdata_idle: if_rdata %h mem_rdata %h without ack", if_rdata, mem_rdata);
      end
      if (if_stall !== (if_req & ~if_ack) || mem_stall !== (mem_req & ~mem_ack)) begin
         tests++; fails++;
         $display("FAIL stall_eq: if_stall %b mem_stall %b", if_stall, mem_stall);
      end
      if (if_ack || mem_ack) begin
         if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_unexpected_ack: if_ack %b mem_ack %b at %0t", if_ack, mem_ack, $time);
         end else begin
            e = sb_q.pop_front();
            check("sb_owner", 32'(mem_ack), 32'(e.is_mem));
            check("sb_rdata", mem_ack ? mem_rdata : if_rdata, e.rdata);
         end
      end
   end

   // Holds requests until the given number of acks per requester arrive.
   task automatic run_until(input int n_if, input int n_mem, input int budget);
      int gi  = 0;
      int gm  = 0;
      int cyc = 0;
      while ((gi < n_if || gm < n_mem) && cyc < budget) begin
         @(negedge clk);
         #1;
         cyc++;
         if (if_ack) begin
            gi++;
            if (gi >= n_if) if_req = 1'b0;
         end
         if (mem_ack) begin
            gm++;
            if (gm >= n_mem) mem_req = 1'b0;
         end
      end
      if_req  = 1'b0;
      mem_req = 1'b0;
      check("run_if_acks", gi, n_if);
      check("run_mem_acks", gm, n_mem);
   endtask

   task automatic do_reset();
      if_req  = 1'b0;
      mem_req = 1'b0;
      rst     = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        mem_req;
      logic        mem_wen;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      int          lat;
      logic        exp_mem_first;
   } vec_t;

   vec_t vecs[6];

   initial begin : main
      int n, cyc_n, got, stall_n, ack_n, bad, bcyc_n, wr_before;

      vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0};
      vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0200, 32'h0,         2, 1'b1};
      vecs[2] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_0108, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         1, 1'b1};
      vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0030, 32'h1234_5678, 3, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_010C, 1'b0, 1'b0, 32'h0,         32'h0,         4, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_bus_cyc",   32'(bus_cyc), 0);
      check("rst_bus_we",    32'(bus_we), 0);
      check("rst_bus_addr",  bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_if_ack",    32'(if_ack), 0);
      check("rst_mem_ack",   32'(mem_ack), 0);
      check("rst_bus_err",   32'(bus_err), 0);
      rst = 1'b0;

      // Minimum latency IF fetch
      @(negedge clk);
      ack_lat = 0;
      if_addr = 32'h0;
      if_req  = 1'b1;
      push_exp(1'b0, 32'h2402_0005);
      #1;
      check("t1_stall_c0", 32'(if_stall), 1);
      check("t1_ack_c0",   32'(if_ack), 0);
      @(negedge clk);
      check("t1_bus_cyc_c1", 32'(bus_cyc), 1);
      check("t1_bus_we_c1",  32'(bus_we), 0);
      check("t1_stall_c1",   32'(if_stall), 1);
      check("t1_ack_c1",     32'(if_ack), 0);
      @(negedge clk);
      check("t1_ack_c2",   32'(if_ack), 1);
      check("t1_rdata_c2", if_rdata, 32'h2402_0005);
      check("t1_stall_c2", 32'(if_stall), 0);
      check("t1_cyc_c2",   32'(bus_cyc), 0);
      if_req = 1'b0;
      @(negedge clk);
      check("t1_ack_c3", 32'(if_ack), 0);

      // Table-driven vectors
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ack_lat   = vecs[i].lat;
         if_addr   = vecs[i].if_addr;
         mem_wen   = vecs[i].mem_wen;
         mem_addr  = vecs[i].mem_addr;
         mem_wdata = vecs[i].mem_wdata;
         if (vecs[i].if_req && vecs[i].mem_req && !vecs[i].exp_mem_first)
            push_exp(1'b0, rd_model(vecs[i].if_addr));
         if (vecs[i].mem_req)
            push_exp(1'b1, vecs[i].mem_wen ? 32'h0 : rd_model(vecs[i].mem_addr));
         if (vecs[i].if_req && !(vecs[i].mem_req && !vecs[i].exp_mem_first))
            push_exp(1'b0, rd_model(vecs[i].if_addr));
         wr_before = wr_cnt;
         if_req    = vecs[i].if_req;
         mem_req   = vecs[i].mem_req;
         run_until(vecs[i].if_req ? 1 : 0, vecs[i].mem_req ? 1 : 0, 60);
         if (vecs[i].mem_req && vecs[i].mem_wen) begin
            check("vec_wr_cnt",  wr_cnt, wr_before + 1);
            check("vec_wr_addr", wr_addr, vecs[i].mem_addr);
            check("vec_wr_data", wr_data, vecs[i].mem_wdata);
         end
      end
      @(negedge clk);
      check("vec_sb_empty", sb_q.size(), 0);

      // Starvation: MEM re-requests every IDLE while IF is held
      do_reset();
      @(negedge clk);
      ack_lat  = 0;
      if_addr  = 32'h0000_0400;
      mem_wen  = 1'b0;
      mem_addr = 32'h0000_0500;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < MS; k++) push_exp(1'b1, rd_model(32'h0000_0500));
         push_exp(1'b0, rd_model(32'h0000_0400));
      end
      if_req  = 1'b1;
      mem_req = 1'b1;
      run_until(2, 2 * MS, 200);
      @(negedge clk);
      check("starve_sb_empty", sb_q.size(), 0);

      // Watchdog timeout on a load
      do_reset();
      check("to_err_before", 32'(bus_err), 0);
      @(negedge clk);
      no_ack   = 1'b1;
      mem_wen  = 1'b0;
      mem_addr = 32'h0000_0600;
      mem_req  = 1'b1;
      push_exp(1'b1, 32'h0);
      cyc_n = 0; got = 0; n = 0;
      while (!got && n < 30) begin
         @(negedge clk);
         #1;
         n++;
         if (bus_cyc) cyc_n++;
         if (mem_ack) begin
            got = 1;
            mem_req = 1'b0;
         end
      end
      mem_req = 1'b0;
      check("to_bus_cyc_cycles", cyc_n, TO);
      check("to_ack_seen", got, 1);
      check("to_bus_err", 32'(bus_err), 1);
      no_ack = 1'b0;
      @(negedge clk);
      ack_lat = 1;
      if_addr = 32'h0000_0110;
      if_req  = 1'b1;
      push_exp(1'b0, rd_model(32'h0000_0110));
      run_until(1, 0, 30);
      check("to_err_sticky", 32'(bus_err), 1);

      // Reset during BUSY
      @(negedge clk);
      no_ack   = 1'b1;
      mem_wen  = 1'b0;
      mem_addr = 32'h0000_0700;
      mem_req  = 1'b1;
      n = 0;
      while (!bus_cyc && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("rst_busy_reached", 32'(bus_cyc), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_cyc", 32'(bus_cyc), 0);
      check("rst_async_err", 32'(bus_err), 0);
      check("rst_async_ack", 32'(mem_ack), 0);
      repeat (2) @(negedge clk);
      check("rst_hold_ack", 32'(mem_ack), 0);
      rst     = 1'b0;
      no_ack  = 1'b0;
      ack_lat = 0;
      push_exp(1'b1, rd_model(32'h0000_0700));
      run_until(0, 1, 30);

      // Late bus_ack on a load
      @(negedge clk);
      ack_lat  = 5;
      mem_wen  = 1'b0;
      mem_addr = 32'h0000_0800;
      mem_req  = 1'b1;
      push_exp(1'b1, rd_model(32'h0000_0800));
      stall_n = 0; ack_n = 0; bad = 0; bcyc_n = 0;
      for (int k = 0; k < 14; k++) begin
         #1;
         if (mem_stall) stall_n++;
         if (bus_cyc) begin
            bcyc_n++;
            if (bus_addr !== 32'h0000_0800 || bus_we !== 1'b0) bad++;
         end
         if (mem_ack) begin
            ack_n++;
            mem_req = 1'b0;
         end
         @(negedge clk);
      end
      mem_req = 1'b0;
      check("late_stall_cycles", stall_n, 7);
      check("late_ack_pulses", ack_n, 1);
      check("late_bus_cyc_cycles", bcyc_n, 6);
      check("late_bus_stable", bad, 0);

      @(negedge clk);
      check("final_sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule
